// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: FSM states, RV32I
// load/store size codes, data width and the access legality rule.
package mem_access_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_STORE     = 3'd2,
    ST_RMW_READ  = 3'd3,
    ST_RMW_WRITE = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // True when the size code is not a legal load/store, or the address is
  // not naturally aligned for the access size.
  function automatic logic access_illegal(input logic       is_load,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    if (is_load) begin
      case (f3)
        F3_LB:   bad = 1'b0;
        F3_LBU:  bad = 1'b0;
        F3_LH:   bad = addr_lo[0];
        F3_LHU:  bad = addr_lo[0];
        F3_LW:   bad = (addr_lo != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = addr_lo[0];
        F3_SW:   bad = (addr_lo != 2'b00);
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side and cache-side signal bundle of the memory access unit.
// slave: the access unit itself; master: the pipeline/cache environment.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              access_err;

  logic              cache_is_input_valid;
  logic [DATA_W-1:0] cache_addr;
  logic              cache_mem_rw;
  logic [DATA_W-1:0] cache_din;
  logic              cache_is_ready;
  logic              cache_is_output_valid;
  logic [DATA_W-1:0] cache_dout;
  logic              cache_is_hit;

  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata,
    output rdata, stall, access_err,
    output cache_is_input_valid, cache_addr, cache_mem_rw, cache_din,
    input  cache_is_ready, cache_is_output_valid, cache_dout, cache_is_hit
  );

  modport master (
    output mem_read, mem_write, funct3, addr, wdata,
    input  rdata, stall, access_err,
    input  cache_is_input_valid, cache_addr, cache_mem_rw, cache_din,
    output cache_is_ready, cache_is_output_valid, cache_dout, cache_is_hit
  );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational byte/halfword lane handling.
// Extracts and sign/zero-extends the addressed lane of a loaded word, and
// merges store data into a previously read word for sub-word stores.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] mod_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword of the returned word
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (byte_off)
      2'd0:    byte_s = rd_word[7:0];
      2'd1:    byte_s = rd_word[15:8];
      2'd2:    byte_s = rd_word[23:16];
      2'd3:    byte_s = rd_word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (byte_off[1]) begin
      half_s = rd_word[31:16];
    end else begin
      half_s = rd_word[15:0];
    end
  end

  // Sign- or zero-extend the selected lane according to the load type
  always_comb begin
    load_data = {DATA_W{1'b0}};
    case (funct3)
      F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  load_data = {24'h000000, byte_s};
      F3_LH:   load_data = {{16{half_s[15]}}, half_s};
      F3_LHU:  load_data = {16'h0000, half_s};
      F3_LW:   load_data = rd_word;
      default: load_data = {DATA_W{1'b0}};
    endcase
  end

  // Replace the addressed byte/halfword lane of the read word with store data
  always_comb begin
    merge_data = mod_word;
    case (funct3)
      F3_SB: begin
        case (byte_off)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          2'd3:    merge_data[31:24] = wdata[7:0];
          default: merge_data = mod_word;
        endcase
      end
      F3_SH: begin
        if (byte_off[1]) begin
          merge_data[31:16] = wdata[15:0];
        end else begin
          merge_data[15:0] = wdata[15:0];
        end
      end
      default: merge_data = mod_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store engine between the pipeline and a
// word-addressed cache. Word accesses go straight to the cache; byte and
// halfword stores use a read-modify-write sequence. Illegal or misaligned
// requests finish immediately with access_err and never touch the cache.
// Optional build macro MEM_ACCESS_STATS_EN adds hit_count/miss_count outputs.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  state_t            state_r;
  state_t            state_next_s;

  logic [DATA_W-1:0] addr_r;
  logic [2:0]        funct3_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] word_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;

  logic              cache_req_s;
  logic              cache_wr_s;
  logic [DATA_W-1:0] cache_din_s;
  logic              rsp_ok_s;
  logic              req_any_s;
  logic              req_bad_s;
  logic [DATA_W-1:0] load_data_s;
  logic [DATA_W-1:0] merge_data_s;

  assign rsp_ok_s  = bus.cache_is_output_valid && bus.cache_is_ready;
  assign req_any_s = bus.mem_read || bus.mem_write;
  // mem_read wins when both requests are present, so it decides the rule
  assign req_bad_s = access_illegal(bus.mem_read, bus.funct3, bus.addr[1:0]);

  mem_lane_align u_lane_align (
    .funct3     (funct3_r),
    .byte_off   (addr_r[1:0]),
    .rd_word    (bus.cache_dout),
    .mod_word   (word_r),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .merge_data (merge_data_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state selection and cache-side request decode
  always_comb begin
    state_next_s = state_r;
    cache_req_s  = 1'b0;
    cache_wr_s   = 1'b0;
    cache_din_s  = {DATA_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (req_any_s && req_bad_s) begin
          state_next_s = ST_DONE;
        end else if (bus.mem_read) begin
          state_next_s = ST_LOAD;
        end else if (bus.mem_write) begin
          if (bus.funct3 == F3_SW) begin
            state_next_s = ST_STORE;
          end else begin
            state_next_s = ST_RMW_READ;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cache_req_s = 1'b1;
        if (rsp_ok_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_RMW_READ: begin
        cache_req_s = 1'b1;
        if (rsp_ok_s) begin
          state_next_s = ST_RMW_WRITE;
        end else begin
          state_next_s = ST_RMW_READ;
        end
      end
      ST_STORE: begin
        cache_req_s = 1'b1;
        cache_wr_s  = 1'b1;
        cache_din_s = wdata_r;
        if (bus.cache_is_ready) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_STORE;
        end
      end
      ST_RMW_WRITE: begin
        cache_req_s = 1'b1;
        cache_wr_s  = 1'b1;
        cache_din_s = merge_data_s;
        if (bus.cache_is_ready) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RMW_WRITE;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Request latches, captured cache word and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r   <= {DATA_W{1'b0}};
      funct3_r <= 3'b000;
      wdata_r  <= {DATA_W{1'b0}};
      word_r   <= {DATA_W{1'b0}};
      rdata_r  <= {DATA_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            addr_r   <= bus.addr;
            funct3_r <= bus.funct3;
            wdata_r  <= bus.wdata;
            rdata_r  <= {DATA_W{1'b0}};
            err_r    <= req_bad_s;
          end
        end
        ST_LOAD: begin
          if (rsp_ok_s) begin
            word_r  <= bus.cache_dout;
            rdata_r <= load_data_s;
          end
        end
        ST_RMW_READ: begin
          if (rsp_ok_s) begin
            word_r <= bus.cache_dout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.cache_is_input_valid = cache_req_s;
  assign bus.cache_mem_rw         = cache_wr_s;
  assign bus.cache_addr           = {addr_r[DATA_W-1:2], 2'b00};
  assign bus.cache_din            = cache_din_s;
  assign bus.rdata                = rdata_r;
  assign bus.access_err           = err_r && (state_r == ST_DONE);
  assign bus.stall                = req_any_s && (state_r != ST_DONE);

`ifdef MEM_ACCESS_STATS_EN
  logic        entered_r;
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  // Mark the first cycle spent in a newly entered state
  always_ff @(posedge clk) begin
    if (reset) begin
      entered_r <= 1'b0;
    end else begin
      entered_r <= (state_next_s != state_r);
    end
  end

  // Classify each cache access once, on its first request cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else if (cache_req_s && entered_r) begin
      if (bus.cache_is_hit) begin
        hit_count_r <= hit_count_r + 32'd1;
      end else begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`else
  logic unused_hit_s;
  assign unused_hit_s = bus.cache_is_hit;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized loads/stores against a small cache model and a reference model
// of RV32I load/store semantics.
module tb_mem_access_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   exp_hits;
  int   exp_misses;

  logic [31:0] cmem    [0:255];
  logic [31:0] ref_mem [0:255];

  mem_access_unit_if bus ();

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  mem_access_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  assign bus.cache_dout = cmem[bus.cache_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_illegal(input logic is_load, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    int unsigned size;
    if (is_load) legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else         legal = f3 inside {3'd0, 3'd1, 3'd2};
    size = 32'd1 << f3[1:0];
    return !legal || ((a % size) != 32'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      3'd2:    return w;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off, input logic [31:0] wd);
    int unsigned sh;
    logic [31:0] mask;
    if (f3 == 3'd2) return wd;
    sh   = (f3 == 3'd0) ? 8 * off : 16 * off[1];
    mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  // One complete pipeline access; entered and left at a falling edge.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int miss);
    logic        is_store, err, rmw, done, rdy;
    logic [31:0] word, exp_rdata, exp_din;
    int          exp_edges, edges, waited, vpulses, writes;
    is_store  = wr && !rd;
    err       = ref_illegal(rd, f3, a);
    rmw       = is_store && (f3 != 3'd2) && !err;
    exp_edges = err ? 1 : ((rmw ? 3 : 2) + miss);
    word      = ref_mem[a[9:2]];
    exp_rdata = (rd && !err) ? ref_load(word, f3, a[1:0]) : 32'd0;
    exp_din   = ref_store(word, f3, a[1:0], wd);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.cache_is_hit = (miss == 0);
    rdy = (miss == 0);
    bus.cache_is_ready = rdy;
    bus.cache_is_output_valid = rdy;
    #1;
    check("stall_on_request", 32'(bus.stall), 32'd1);
    edges = 0; waited = 0; vpulses = 0; writes = 0; done = 1'b0;
    while (!done && edges < 80) begin
      @(posedge clk);
      #1;
      edges++;
      // Latched values must be used: scribble over the request fields
      bus.addr   = $urandom;
      bus.funct3 = 3'($urandom);
      bus.wdata  = $urandom;
      if (!bus.stall) begin
        done = 1'b1;
      end else if (bus.cache_is_input_valid) begin
        vpulses++;
        check("cache_addr", bus.cache_addr, {a[31:2], 2'b00});
        rdy = (waited >= miss);
        if (!rdy) waited++;
        bus.cache_is_ready = rdy;
        bus.cache_is_output_valid = rdy;
        if (bus.cache_mem_rw && rdy) begin
          writes++;
          check("cache_din", bus.cache_din, exp_din);
          cmem[bus.cache_addr[9:2]] = bus.cache_din;
        end
      end
    end
    check("reached_done", 32'(done), 32'd1);
    check("latency", 32'(edges), 32'(exp_edges));
    check("rdata", bus.rdata, exp_rdata);
    check("access_err", 32'(bus.access_err), 32'(err));
    check("cache_used", 32'(vpulses > 0), 32'(!err));
    check("write_count", 32'(writes), 32'(is_store && !err));
    if (is_store && !err) ref_mem[a[9:2]] = exp_din;
    if (!err) begin
      if (miss == 0) exp_hits   += rmw ? 2 : 1;
      else           exp_misses += rmw ? 2 : 1;
    end
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.cache_is_ready = 1'b0;
    bus.cache_is_output_valid = 1'b0;
    check("rdata_held", bus.rdata, exp_rdata);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra;
    vectors = 0; miscompares = 0; exp_hits = 0; exp_misses = 0;
    reset = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.funct3 = 3'd0;
    bus.addr = 32'd0; bus.wdata = 32'd0;
    bus.cache_is_ready = 1'b0; bus.cache_is_output_valid = 1'b0; bus.cache_is_hit = 1'b0;
    for (int i = 0; i < 256; i++) begin
      cmem[i] = $urandom;
      ref_mem[i] = cmem[i];
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.cache_is_input_valid), 32'd0);
    check("rst_rw", 32'(bus.cache_mem_rw), 32'd0);
    check("rst_addr", bus.cache_addr, 32'd0);
    check("rst_din", bus.cache_din, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_err", 32'(bus.access_err), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
`ifdef MEM_ACCESS_STATS_EN
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Loads from a preloaded word, hit and miss
    cmem[8'h40] = 32'h8081_F2F3; ref_mem[8'h40] = 32'h8081_F2F3;
    do_access(1'b1, 1'b0, 3'b000, 32'h101, 32'd0, 0);
    check("lb_0x101", bus.rdata, 32'hFFFF_FFF2);
    do_access(1'b1, 1'b0, 3'b100, 32'h101, 32'd0, 0);
    check("lbu_0x101", bus.rdata, 32'h0000_00F2);
    do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 20);
    check("lh_miss_0x102", bus.rdata, 32'hFFFF_8081);

    // Sub-word store via read-modify-write
    cmem[8'h40] = 32'h1122_3344; ref_mem[8'h40] = 32'h1122_3344;
    do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00AA, 0);
    check("sb_word", cmem[8'h40], 32'hAA22_3344);

    // Misaligned word load, illegal store code, read priority
    do_access(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 0);
    do_access(1'b0, 1'b1, 3'b011, 32'h104, 32'h1234_5678, 0);
    do_access(1'b1, 1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 0);

    // Reset in the middle of a load miss
    bus.mem_read = 1'b1; bus.funct3 = 3'b001; bus.addr = 32'h102;
    bus.cache_is_hit = 1'b0; bus.cache_is_ready = 1'b0; bus.cache_is_output_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("miss_pending_valid", 32'(bus.cache_is_input_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", 32'(bus.cache_is_input_valid), 32'd0);
    check("rst_mid_addr", bus.cache_addr, 32'd0);
    check("rst_mid_stall", 32'(bus.stall), 32'd1);
    exp_hits = 0; exp_misses = 0;
    @(negedge clk);
    reset = 1'b0;
    bus.mem_read = 1'b0;
    @(negedge clk);

    // Three hits and two misses
    for (int i = 0; i < 3; i++) do_access(1'b1, 1'b0, 3'b010, 32'(i * 4), 32'd0, 0);
    for (int i = 0; i < 2; i++) do_access(1'b1, 1'b0, 3'b010, 32'(i * 4 + 16), 32'd0, 3);
`ifdef MEM_ACCESS_STATS_EN
    check("hit_count_3", hit_count, 32'd3);
    check("miss_count_2", miss_count, 32'd2);
`endif

    // Randomized traffic, biased toward legal aligned accesses
    for (int i = 0; i < 80; i++) begin
      ra = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      do_access(1'($urandom_range(0, 1)), 1'b1, 3'($urandom_range(0, 7)), ra,
                $urandom, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0);
    end
    for (int i = 0; i < 20; i++) begin
      ra = 32'($urandom_range(0, 1023));
      do_access(1'b1, 1'b0, 3'($urandom_range(0, 7)), ra, 32'd0, 0);
    end
`ifdef MEM_ACCESS_STATS_EN
    check("hit_count_end", hit_count, 32'(exp_hits));
    check("miss_count_end", miss_count, 32'(exp_misses));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 SHALL have pipeline-side inputs: mem_read  input  1  load request; mem_write  input  1  store request; funct3  input  3  RV32I size/sign code; addr  input  32  byte address; wdata  input  32  store data.
REQ-003 SHALL have pipeline-side outputs: rdata  output  32  extended load result; stall  output  1  hold pipeline; access_err  output  1  misaligned or illegal funct3, valid in DONE.
REQ-004 SHALL have cache-side outputs: cache_is_input_valid  output  1; cache_addr  output  32  word-aligned (addr[1:0]=0); cache_mem_rw  output  1  (1=write); cache_din  output  32.
REQ-005 SHALL have cache-side inputs: cache_is_ready  input  1; cache_is_output_valid  input  1; cache_dout  input  32; cache_is_hit  input  1.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, DONE.
REQ-007 In IDLE with mem_read=1, SHALL latch addr/funct3 and go to LOAD; mem_read has priority when both requests are high.
REQ-008 In IDLE with mem_write=1 and funct3=010 (SW), SHALL go to STORE; with SB/SH, SHALL go to RMW_READ.
REQ-009 Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or illegal funct3 (loads: 011,110,111; stores: anything but 000/001/010) SHALL go directly to DONE with access_err=1, rdata=0, and no cache request.
REQ-010 cache_is_input_valid SHALL be 1 exactly in LOAD, STORE, RMW_READ, RMW_WRITE; cache_mem_rw=1 only in STORE and RMW_WRITE.
REQ-011 LOAD/RMW_READ SHALL advance when cache_is_output_valid && cache_is_ready, capturing cache_dout into a word register.
REQ-012 STORE/RMW_WRITE SHALL advance to DONE when cache_is_ready=1.
REQ-013 RMW_WRITE SHALL drive cache_din = captured word with byte lane addr[1:0] (SB) or halfword lane addr[1] (SH) replaced by wdata[7:0]/wdata[15:0].
REQ-014 rdata SHALL be byte/halfword selected by addr[1:0], sign-extended for LB/LH and zero-extended for LBU/LHU; it is held stable in DONE and is 0 for stores.
REQ-015 stall SHALL be (mem_read|mem_write) && state!=DONE, combinationally.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 Hit latency: LW/SW hit SHALL complete in 3 cycles (IDLE, LOAD/STORE, DONE); SB/SH hit in 4 cycles.
REQ-018 Request inputs SHALL be ignored outside IDLE; latched values are used until DONE.

Reset
REQ-019 On reset, the FSM SHALL go to IDLE and the data/address latches SHALL clear to 0; any in-flight cache request SHALL be abandoned.
REQ-020 Reset outputs SHALL be: cache_is_input_valid=0, cache_mem_rw=0, cache_addr=0, cache_din=0, rdata=0, access_err=0; stall follows REQ-015.

Configuration
REQ-021 With MEM_ACCESS_STATS_EN defined, SHALL add outputs hit_count and miss_count (each output 32), reset to 0, each incremented once per cache access on its first request cycle per cache_is_hit; the counters SHALL wrap at 2^32.
REQ-022 Without MEM_ACCESS_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-023 A shared package SHALL hold the state enum, funct3 constants (LB,LH,LW,LBU,LHU,SB,SH,SW), and DATA_W=32.
REQ-024 Lane extract/merge SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-025 Cache preloaded so that word 0x100 = 0x8081_F2F3 (hit): LB addr 0x101 -> rdata 0xFFFF_FFF2; LBU -> 0x0000_00F2; stall high for 2 cycles.
REQ-026 LH addr 0x102 on a miss (cache_is_ready low for 20 cycles) -> stall held for the full duration, rdata 0xFFFF_8081, cache_addr 0x100.
REQ-027 SB addr 0x103, wdata 0xAA, word 0x100 = 0x1122_3344 -> RMW_WRITE cache_din 0xAA22_3344, cache_mem_rw=1; completes in 4 cycles on a hit.
REQ-028 LW addr 0x102 -> access_err=1, no cache_is_input_valid pulse, stall 1 cycle.
REQ-029 Reset asserted in LOAD mid-miss -> next cycle IDLE, cache_is_input_valid=0; with MEM_ACCESS_STATS_EN, 3 hits and 2 misses -> hit_count=3, miss_count=2.
